i2c_reg_arbiter: RTL and testbench

I2C_REG_ARBITER -- requirements
Module: i2c_reg_arbiter

---
 rtl/i2c_reg_arbiter.sv | 138 +++++++++++++
 tb/tb_i2c_reg_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_arbiter.sv
// Arbitrates a single register-file port between an I2C slave front end and a
// host bus. The I2C side gets a one-deep write buffer and a coherent read-back register.
module i2c_reg_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  input  logic              i2c_we,
  output logic [DATA_W-1:0] i2c_rdata,
  output logic              i2c_ovf,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              rf_re,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    I2C_WR   = 3'd1,
    I2C_RD   = 3'd2,
    I2C_CAP  = 3'd3,
    HOST_WR  = 3'd4,
    HOST_RD  = 3'd5,
    HOST_CAP = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   w_rf_addr;
  logic [DATA_W-1:0]   w_rf_wdata;
  logic                w_host_grant;
  logic                w_rd_set;
  logic                r_wr_pend;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_rd_pend;
  logic [ADDR_W-1:0]   r_addr_q;

  assign o_dbg_state = r_state;

  // Host handshake: host_req is held with stable host_we/addr/wdata until the
  // one-cycle host_ack; req is ignored in the ack cycle itself and counts as a
  // new request from the following cycle. A same-cycle I2C strobe also defers
  // the grant so the strobe lands in wr_pend and wins arbitration next cycle.
  assign w_host_grant = host_req && !host_ack && !i2c_we;

  // Any change of the I2C pointer, or any write landing on it, stales i2c_rdata.
  assign w_rd_set = (i2c_addr != r_addr_q) || (rf_we && (rf_addr == i2c_addr));

  always_comb begin
    w_next     = r_state;
    w_rf_addr  = rf_addr;
    w_rf_wdata = rf_wdata;
    case (r_state)
      IDLE: begin
        if (r_wr_pend) begin
          w_next     = I2C_WR;
          w_rf_addr  = r_wr_addr;
          w_rf_wdata = r_wr_data;
        end else if (r_rd_pend) begin
          w_next    = I2C_RD;
          w_rf_addr = i2c_addr;
        end else if (w_host_grant) begin
          w_next    = host_we ? HOST_WR : HOST_RD;
          w_rf_addr = host_addr;
          if (host_we) w_rf_wdata = host_wdata;
        end
      end
      I2C_WR:   w_next = IDLE;
      I2C_RD:   w_next = I2C_CAP;
      I2C_CAP:  w_next = IDLE;
      HOST_WR:  w_next = IDLE;
      HOST_RD:  w_next = HOST_CAP;
      HOST_CAP: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Register-file strobes are registered off the next state so they are high
  // for exactly the cycle spent in the matching access state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      rf_we      <= 1'b0;
      rf_re      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      i2c_rdata  <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      r_state  <= w_next;
      rf_we    <= (w_next == I2C_WR) || (w_next == HOST_WR);
      rf_re    <= (w_next == I2C_RD) || (w_next == HOST_RD);
      rf_addr  <= w_rf_addr;
      rf_wdata <= w_rf_wdata;
      host_ack <= (r_state == HOST_WR) || (r_state == HOST_CAP);
      if (r_state == HOST_CAP) host_rdata <= rf_rdata;
      if (r_state == I2C_CAP)  i2c_rdata  <= rf_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_pend <= 1'b1;
      r_addr_q  <= '0;
      i2c_ovf   <= 1'b0;
    end else begin
      r_addr_q <= i2c_addr;
      if (i2c_we) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= i2c_addr;
        r_wr_data <= i2c_wdata;
      end else if (r_state == I2C_WR) begin
        r_wr_pend <= 1'b0;
      end
      if (i2c_we && r_wr_pend) i2c_ovf <= 1'b1;
      // A pointer move during I2C_RD/I2C_CAP re-arms the refresh: last address wins.
      if (w_rd_set)                r_rd_pend <= 1'b1;
      else if (r_state == I2C_RD)  r_rd_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter: a behavioural register file on the rf_*
// port, expected-value queues filled by the stimulus, and negedge monitors.
module tb_i2c_reg_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOST_RD = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] i2c_addr = '0;
  logic [DW-1:0] i2c_wdata = '0;
  logic          i2c_we = 1'b0;
  logic [DW-1:0] i2c_rdata;
  logic          i2c_ovf;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic          rf_we;
  logic          rf_re;
  logic [DW-1:0] rf_rdata = '0;
  logic [2:0]    o_dbg_state;

  i2c_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_we(i2c_we),
    .i2c_rdata(i2c_rdata), .i2c_ovf(i2c_ovf),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_re(rf_re),
    .rf_rdata(rf_rdata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  // ---------------- register file model ----------------
  logic [DW-1:0] mem [256] = '{default: 8'h00};
  logic          wr_seen [256] = '{default: 1'b0};

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      8'h00:   return 8'h5A;
      8'h11:   return 8'h3C;
      8'h30:   return 8'hC3;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_addr]     <= rf_wdata;
      wr_seen[rf_addr] <= 1'b1;
    end
    if (rf_re) rf_rdata <= wr_seen[rf_addr] ? mem[rf_addr] : rom(rf_addr);
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  bit            mon_en = 1'b0;
  logic [16:0]   exp_q[$];   // {is_write, addr, wdata (0 for reads)}
  logic [DW-1:0] ack_q[$];   // host_rdata seen with each host_ack
  logic [DW-1:0] rdq[$];     // successive i2c_rdata values
  logic [DW-1:0] prev_rdata = '0;
  logic [16:0]   mon_txn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h expected no event (t=%0t)", name, act, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en && (rf_we || rf_re)) begin
      mon_txn = rf_we ? {1'b1, rf_addr, rf_wdata} : {1'b0, rf_addr, 8'h00};
      check("rf_we_re_exclusive", {31'd0, rf_we & rf_re}, 32'd0);
      if (exp_q.size() == 0) unexpected("rf_txn_extra", {15'd0, mon_txn});
      else check("rf_txn", {15'd0, mon_txn}, {15'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (mon_en && host_ack) begin
      if (ack_q.size() == 0) unexpected("host_ack_extra", {24'd0, host_rdata});
      else check("host_rdata", {24'd0, host_rdata}, {24'd0, ack_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (mon_en && (i2c_rdata !== prev_rdata)) begin
      if (rdq.size() == 0) unexpected("i2c_rdata_extra", {24'd0, i2c_rdata});
      else check("i2c_rdata", {24'd0, i2c_rdata}, {24'd0, rdq.pop_front()});
    end
    prev_rdata = i2c_rdata;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() + ack_q.size() + rdq.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if ((exp_q.size() + ack_q.size() + rdq.size()) != 0) begin
      unexpected("drain_timeout", exp_q.size() + ack_q.size() + rdq.size());
      exp_q.delete();
      ack_q.delete();
      rdq.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic i2c_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i2c_addr  = a;
    i2c_wdata = d;
    i2c_we    = 1'b1;
    @(posedge clk);
    #1;
    i2c_we = 1'b0;
  endtask

  task automatic host_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  task automatic host_wait(input bit drop);
    int n = 0;
    while (host_ack !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("host_ack_seen", {31'd0, host_ack}, 32'd1);
    if (drop) host_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"},      {31'd0, rf_we}, 32'd0);
    check({tag, "_rf_re"},      {31'd0, rf_re}, 32'd0);
    check({tag, "_rf_addr"},    {24'd0, rf_addr}, 32'd0);
    check({tag, "_rf_wdata"},   {24'd0, rf_wdata}, 32'd0);
    check({tag, "_i2c_rdata"},  {24'd0, i2c_rdata}, 32'd0);
    check({tag, "_i2c_ovf"},    {31'd0, i2c_ovf}, 32'd0);
    check({tag, "_host_ack"},   {31'd0, host_ack}, 32'd0);
    check({tag, "_host_rdata"}, {24'd0, host_rdata}, 32'd0);
    check({tag, "_state"},      {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    mon_en = 1'b1;

    // Prefetch of address 0 after reset release.
    exp_q.push_back({1'b0, 8'h00, 8'h00});
    rdq.push_back(8'h5A);
    rst = 1'b0;
    wait_quiet();

    // I2C write to 0x10, then pointer moves to 0x11.
    exp_q.push_back({1'b1, 8'h10, 8'hA5});
    exp_q.push_back({1'b0, 8'h10, 8'h00});
    rdq.push_back(8'hA5);
    i2c_write(8'h10, 8'hA5);
    wait_quiet();
    exp_q.push_back({1'b0, 8'h11, 8'h00});
    rdq.push_back(8'h3C);
    i2c_addr = 8'h11;
    wait_quiet();

    // Host write and I2C write in the same cycle: I2C write and its refresh first.
    exp_q.push_back({1'b1, 8'h21, 8'h99});
    exp_q.push_back({1'b0, 8'h21, 8'h00});
    exp_q.push_back({1'b1, 8'h20, 8'h42});
    ack_q.push_back(8'h00);
    rdq.push_back(8'h99);
    host_start(1'b1, 8'h20, 8'h42);
    i2c_write(8'h21, 8'h99);
    host_wait(1'b1);
    wait_quiet();

    // Host write onto the current I2C pointer forces a refresh.
    exp_q.push_back({1'b1, 8'h21, 8'h77});
    exp_q.push_back({1'b0, 8'h21, 8'h00});
    ack_q.push_back(8'h00);
    rdq.push_back(8'h77);
    host_start(1'b1, 8'h21, 8'h77);
    host_wait(1'b1);
    wait_quiet();
    check("ovf_before_overrun", {31'd0, i2c_ovf}, 32'd0);

    // Two strobes while a host read is in flight: only the second survives.
    exp_q.push_back({1'b0, 8'h30, 8'h00});
    exp_q.push_back({1'b1, 8'h41, 8'h22});
    exp_q.push_back({1'b0, 8'h41, 8'h00});
    ack_q.push_back(8'hC3);
    rdq.push_back(8'h22);
    host_start(1'b0, 8'h30, 8'h00);
    @(posedge clk);
    #1;
    i2c_addr  = 8'h40;
    i2c_wdata = 8'h11;
    i2c_we    = 1'b1;
    @(posedge clk);
    #1;
    i2c_addr  = 8'h41;
    i2c_wdata = 8'h22;
    @(posedge clk);
    #1;
    i2c_we = 1'b0;
    host_wait(1'b1);
    wait_quiet();
    check("ovf_after_overrun", {31'd0, i2c_ovf}, 32'd1);

    // Reset while a host read is in HOST_RD: no ack, everything back to reset values.
    host_start(1'b0, 8'h30, 8'h00);
    @(posedge clk);
    #1;
    check("state_host_rd", {29'd0, o_dbg_state}, {29'd0, ST_HOST_RD});
    rdq.push_back(8'h00);
    rst      = 1'b1;
    host_req = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back({1'b0, 8'h41, 8'h00});
    rdq.push_back(8'h22);
    rst = 1'b0;
    wait_quiet();
    check("ovf_after_rst", {31'd0, i2c_ovf}, 32'd0);

    // host_req held into the cycle after host_ack is a second request.
    exp_q.push_back({1'b1, 8'h50, 8'h66});
    exp_q.push_back({1'b1, 8'h50, 8'h66});
    ack_q.push_back(8'h00);
    ack_q.push_back(8'h00);
    host_start(1'b1, 8'h50, 8'h66);
    host_wait(1'b0);
    @(posedge clk);
    #1;
    host_wait(1'b1);
    wait_quiet();

    // Host read back of the host-written location.
    exp_q.push_back({1'b0, 8'h50, 8'h00});
    ack_q.push_back(8'h66);
    host_start(1'b0, 8'h50, 8'h00);
    host_wait(1'b1);
    wait_quiet();

    check("exp_q_empty", exp_q.size(), 32'd0);
    check("ack_q_empty", ack_q.size(), 32'd0);
    check("rdq_empty",   rdq.size(), 32'd0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
